// File: rtl/dense_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dense_pkg
// Brief    : Shared constants, logit type and scan-state encoding for the
//            dense classifier datapath (dense_top / dense_argmax).
// Revision : 1.0 - initial release
// ============================================================================
package dense_pkg;

    localparam int DENSE_DATA_WIDTH = 8;
    localparam int DENSE_NUM_CLASS  = 7;

    typedef logic signed [DENSE_DATA_WIDTH-1:0] logit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage : dense_pkg
`default_nettype wire

// File: rtl/dense_argmax_top2_update.sv
`default_nettype none
// ============================================================================
// Module   : top2_update
// Brief    : Combinational top-2 tracker step. Folds one candidate logit into
//            the running (best, second, best_idx) triple. Strict compare on
//            best keeps the lowest index on ties; an equal value still lands
//            in second so a tie reports a zero margin.
// Revision : 1.0 - initial release
// ============================================================================
module top2_update
    import dense_pkg::*;
#(
    parameter int   DATA_WIDTH = DENSE_DATA_WIDTH,
    parameter int   NUM_CLASS  = DENSE_NUM_CLASS,
    localparam int  IDX_WIDTH  = $clog2(NUM_CLASS)
) (
    input  logic signed [DATA_WIDTH-1:0] i_best,
    input  logic signed [DATA_WIDTH-1:0] i_second,
    input  logic        [IDX_WIDTH-1:0]  i_best_idx,
    input  logic signed [DATA_WIDTH-1:0] i_cand,
    input  logic        [IDX_WIDTH-1:0]  i_cand_idx,
    output logic signed [DATA_WIDTH-1:0] o_best,
    output logic signed [DATA_WIDTH-1:0] o_second,
    output logic        [IDX_WIDTH-1:0]  o_best_idx
);

    // Signed compare of the candidate against the current top-2 pair
    always_comb begin
        o_best     = i_best;
        o_second   = i_second;
        o_best_idx = i_best_idx;
        if (i_cand > i_best) begin
            o_second   = i_best;
            o_best     = i_cand;
            o_best_idx = i_cand_idx;
        end else if (i_cand > i_second) begin
            o_second   = i_cand;
        end
    end

endmodule : top2_update
`default_nettype wire

// File: rtl/dense_argmax.sv
`default_nettype none
// ============================================================================
// Module   : dense_argmax
// Brief    : Serial argmax over the dense_top logit vector. Latches the vector
//            on valid_i, scans one lane per cycle and reports the winning
//            class, its logit and the top-1/top-2 margin with a result strobe.
//            Vectors arriving mid-scan are dropped and flagged on drop_o.
// Revision : 1.0 - initial release
// ============================================================================
module dense_argmax
    import dense_pkg::*;
#(
    parameter int   DATA_WIDTH = DENSE_DATA_WIDTH,
    parameter int   NUM_CLASS  = DENSE_NUM_CLASS,
    localparam int  IDX_WIDTH  = $clog2(NUM_CLASS)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [DATA_WIDTH*NUM_CLASS-1:0] data_i,
    input  logic                            valid_i,
    output logic                            busy_o,
    output logic [IDX_WIDTH-1:0]            class_o,
    output logic [DATA_WIDTH-1:0]           max_o,
    output logic [DATA_WIDTH:0]             margin_o,
    output logic                            valid_o,
    output logic                            drop_o
);

    localparam logic signed [DATA_WIDTH-1:0] c_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]         c_LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

    state_t                          r_state;
    logic signed [DATA_WIDTH-1:0]    r_lane [NUM_CLASS];
    logic signed [DATA_WIDTH-1:0]    r_best;
    logic signed [DATA_WIDTH-1:0]    r_second;
    logic        [IDX_WIDTH-1:0]     r_best_idx;
    logic        [IDX_WIDTH-1:0]     r_idx;

    logic signed [DATA_WIDTH-1:0]    w_nbest;
    logic signed [DATA_WIDTH-1:0]    w_nsecond;
    logic        [IDX_WIDTH-1:0]     w_nbest_idx;
    logic        [DATA_WIDTH:0]      w_margin;

    top2_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CLASS  (NUM_CLASS)
    ) u_top2 (
        .i_best     (r_best),
        .i_second   (r_second),
        .i_best_idx (r_best_idx),
        .i_cand     (r_lane[r_idx]),
        .i_cand_idx (r_idx),
        .o_best     (w_nbest),
        .o_second   (w_nsecond),
        .o_best_idx (w_nbest_idx)
    );

    // Sign-extend one bit so best-second never overflows; best >= second keeps it non-negative
    assign w_margin = {w_nbest[DATA_WIDTH-1], w_nbest} - {w_nsecond[DATA_WIDTH-1], w_nsecond};

    // Scan FSM, lane counter, top-2 state and registered result outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_best     <= '0;
            r_second   <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
            for (int k = 0; k < NUM_CLASS; k++) begin
                r_lane[k] <= '0;
            end
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            drop_o     <= 1'b0;
            class_o    <= '0;
            max_o      <= '0;
            margin_o   <= '0;
        end else begin
            valid_o <= 1'b0;
            drop_o  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        for (int k = 0; k < NUM_CLASS; k++) begin
                            r_lane[k] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_best     <= data_i[DATA_WIDTH-1:0];
                        r_second   <= c_MOST_NEG;
                        r_best_idx <= '0;
                        r_idx      <= IDX_WIDTH'(1);
                        busy_o     <= 1'b1;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    drop_o     <= valid_i;
                    r_best     <= w_nbest;
                    r_second   <= w_nsecond;
                    r_best_idx <= w_nbest_idx;
                    r_idx      <= r_idx + IDX_WIDTH'(1);
                    if (r_idx == c_LAST_IDX) begin
                        class_o  <= w_nbest_idx;
                        max_o    <= w_nbest;
                        margin_o <= w_margin;
                        valid_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        r_idx    <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : dense_argmax
`default_nettype wire

// File: tb/tb_dense_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_argmax
// Brief    : Directed self-checking bench for dense_argmax.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_argmax;

    localparam int DW = 8;
    localparam int NC = 7;
    localparam int IW = $clog2(NC);

    logic              clk;
    logic              rstn;
    logic [DW*NC-1:0]  data_i;
    logic              valid_i;
    logic              busy_o;
    logic [IW-1:0]     class_o;
    logic [DW-1:0]     max_o;
    logic [DW:0]       margin_o;
    logic              valid_o;
    logic              drop_o;

    int n_cmp;
    int n_err;

    dense_argmax #(.DATA_WIDTH(DW), .NUM_CLASS(NC)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .busy_o   (busy_o),
        .class_o  (class_o),
        .max_o    (max_o),
        .margin_o (margin_o),
        .valid_o  (valid_o),
        .drop_o   (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*NC-1:0] pack(input logic [7:0] l0, l1, l2, l3, l4, l5, l6);
        return {l6, l5, l4, l3, l2, l1, l0};
    endfunction

    // Present a vector for one edge (E0); returns right after E0
    task automatic send(input logic [DW*NC-1:0] v);
        data_i  = v;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; valid_i = 1'b0; data_i = '0;
        tick(); tick();
        n_cmp++;
        if ({busy_o, valid_o, drop_o, class_o, max_o, margin_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b valid=%b drop=%b class=%0d max=%h margin=%h, want all 0",
                     busy_o, valid_o, drop_o, class_o, max_o, margin_o);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send(pack(8'h05, 8'h12, 8'h7F, 8'h40, 8'hF0, 8'h00, 8'h33));
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL basic_busy c%0d: got busy=%b valid=%b, want busy=1 valid=0", c, busy_o, valid_o);
            end
            if (c < 6) tick();
        end
        tick(); // edge E0+6
        n_cmp++;
        if (valid_o !== 1'b1 || busy_o !== 1'b0 || class_o !== 3'd2 || max_o !== 8'h7F || margin_o !== 9'h03F) begin
            n_err++;
            $display("FAIL basic_result: got v=%b busy=%b class=%0d max=%h margin=%h, want v=1 busy=0 class=2 max=7f margin=03f",
                     valid_o, busy_o, class_o, max_o, margin_o);
        end
        tick();
        n_cmp++;
        if (valid_o !== 1'b0 || class_o !== 3'd2 || max_o !== 8'h7F || margin_o !== 9'h03F) begin
            n_err++;
            $display("FAIL basic_hold: got v=%b class=%0d max=%h margin=%h, want v=0 class=2 max=7f margin=03f",
                     valid_o, class_o, max_o, margin_o);
        end
    endtask

    task automatic test_signed();
        send(pack(8'h80, 8'h81, 8'hFF, 8'h90, 8'hFE, 8'hA0, 8'hC0));
        repeat (6) tick();
        n_cmp++;
        if (valid_o !== 1'b1 || class_o !== 3'd2 || max_o !== 8'hFF || margin_o !== 9'h001) begin
            n_err++;
            $display("FAIL neg_result: got v=%b class=%0d max=%h margin=%h, want v=1 class=2 max=ff margin=001",
                     valid_o, class_o, max_o, margin_o);
        end
        tick();
        send(pack(8'h7F, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80));
        repeat (6) tick();
        n_cmp++;
        if (valid_o !== 1'b1 || class_o !== 3'd0 || max_o !== 8'h7F || margin_o !== 9'h080) begin
            n_err++;
            $display("FAIL signed_cmp: got v=%b class=%0d max=%h margin=%h, want v=1 class=0 max=7f margin=080",
                     valid_o, class_o, max_o, margin_o);
        end
        tick();
    endtask

    task automatic test_tie();
        send(pack(8'h10, 8'h30, 8'h10, 8'h10, 8'h10, 8'h30, 8'h10));
        repeat (6) tick();
        n_cmp++;
        if (valid_o !== 1'b1 || class_o !== 3'd1 || max_o !== 8'h30 || margin_o !== 9'h000) begin
            n_err++;
            $display("FAIL tie: got v=%b class=%0d max=%h margin=%h, want v=1 class=1 max=30 margin=000",
                     valid_o, class_o, max_o, margin_o);
        end
        tick();
    endtask

    task automatic test_full_range();
        send(pack(8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80));
        repeat (6) tick();
        n_cmp++;
        if (valid_o !== 1'b1 || class_o !== 3'd0 || max_o !== 8'h7F || margin_o !== 9'h0FF) begin
            n_err++;
            $display("FAIL full_range: got v=%b class=%0d max=%h margin=%h, want v=1 class=0 max=7f margin=0ff",
                     valid_o, class_o, max_o, margin_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW*NC-1:0] vb;
        logic [DW*NC-1:0] vc;
        vb = pack(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        vc = pack(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h20);
        // Vector A at E0 (winner lane 3 = 0x50, second lane 6 = 0x48)
        send(pack(8'h11, 8'h22, 8'h33, 8'h50, 8'h00, 8'hC0, 8'h48));
        tick(); tick();                       // E0+1, E0+2
        data_i = vb; valid_i = 1'b1;
        tick();                               // E0+3: B dropped
        valid_i = 1'b0;
        n_cmp++;
        if (drop_o !== 1'b1 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL drop_b: got drop=%b busy=%b, want drop=1 busy=1", drop_o, busy_o);
        end
        tick();                               // E0+4
        n_cmp++;
        if (drop_o !== 1'b0) begin
            n_err++;
            $display("FAIL drop_pulse: got drop=%b, want 0", drop_o);
        end
        tick();                               // E0+5
        data_i = vc; valid_i = 1'b1;
        tick();                               // E0+6: final lane of A, C dropped
        n_cmp++;
        if (valid_o !== 1'b1 || drop_o !== 1'b1 || class_o !== 3'd3 || max_o !== 8'h50 || margin_o !== 9'h008) begin
            n_err++;
            $display("FAIL result_a: got v=%b drop=%b class=%0d max=%h margin=%h, want v=1 drop=1 class=3 max=50 margin=008",
                     valid_o, drop_o, class_o, max_o, margin_o);
        end
        tick();                               // E0+7: C accepted
        valid_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b1 || drop_o !== 1'b0 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL accept_c: got busy=%b drop=%b v=%b, want busy=1 drop=0 v=0", busy_o, drop_o, valid_o);
        end
        repeat (5) tick();                    // E0+8..E0+12
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL early_c: got v=%b at E0+12, want 0", valid_o);
        end
        tick();                               // E0+13
        n_cmp++;
        if (valid_o !== 1'b1 || class_o !== 3'd6 || max_o !== 8'h20 || margin_o !== 9'h01A) begin
            n_err++;
            $display("FAIL result_c: got v=%b class=%0d max=%h margin=%h, want v=1 class=6 max=20 margin=01a",
                     valid_o, class_o, max_o, margin_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        send(pack(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07));
        tick(); tick();                       // E0+1, E0+2
        rstn = 1'b0;
        tick();                               // E0+3
        n_cmp++;
        if ({busy_o, valid_o, drop_o, class_o, max_o, margin_o} !== '0) begin
            n_err++;
            $display("FAIL midscan_reset: got busy=%b v=%b drop=%b class=%0d max=%h margin=%h, want all 0",
                     busy_o, valid_o, drop_o, class_o, max_o, margin_o);
        end
        tick();                               // E0+4
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL aborted_scan: got %0d cycles with valid/busy after reset, want 0", seen);
        end
        send(pack(8'hE0, 8'h05, 8'h44, 8'h3C, 8'h44, 8'h10, 8'hF8));
        repeat (6) tick();
        n_cmp++;
        if (valid_o !== 1'b1 || class_o !== 3'd2 || max_o !== 8'h44 || margin_o !== 9'h000) begin
            n_err++;
            $display("FAIL post_reset: got v=%b class=%0d max=%h margin=%h, want v=1 class=2 max=44 margin=000",
                     valid_o, class_o, max_o, margin_o);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0; valid_i = 1'b0; data_i = '0;
        test_reset();
        test_basic();
        test_signed();
        test_tie();
        test_full_range();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dense_argmax
`default_nettype wire

// File: doc/dense_argmax.md
Name: dense_argmax

Overview:
- Classifier stage directly downstream of dense_top.
- Consumes the single-cycle 7-logit vector (data_o/valid_o of dense_top) and scans it serially, one lane per cycle.
- Produces the winning class index, its logit, and the top-1 to top-2 confidence margin, with a one-cycle result strobe.
- Feeds the result/LED/UART reporting logic.

Parameters:
- DATA_WIDTH, 8, width of one logit, signed two's complement
- NUM_CLASS, 7, number of logits per vector (≥2)
- IDX_WIDTH, $clog2(NUM_CLASS), width of class index (derived localparam, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  synchronous active-low reset
- data_i  in  DATA_WIDTH*NUM_CLASS  logit vector; lane k = data_i[k*DATA_WIDTH +: DATA_WIDTH]
- valid_i  in  1  one-cycle strobe qualifying data_i
- busy_o  out  1  high while scanning; valid_i is dropped while busy_o is high
- class_o  out  IDX_WIDTH  index of maximum logit
- max_o  out  DATA_WIDTH  value of maximum logit
- margin_o  out  DATA_WIDTH+1  max minus second-largest, unsigned
- valid_o  out  1  one-cycle result strobe
- drop_o  out  1  one-cycle pulse: valid_i arrived while busy

Behaviour:
- Reset: rstn is sampled at posedge. When low, the state goes to IDLE and all outputs become 0 (busy_o, valid_o, drop_o, class_o, max_o, margin_o). Reset overrides everything, including mid-scan; an aborted scan never produces valid_o.
- FSM states are IDLE and SCAN.
- IDLE + valid_i at edge E0:
  - latch data_i into the vector register
  - best_idx=0, best=lane0, second=most-negative value (-2^(DATA_WIDTH-1)), idx=1
  - go to SCAN; busy_o=1
- SCAN, each edge, v = lane[idx]:
  - if v > best (signed, strict): second=best, best=v, best_idx=idx
  - else if v > second: second=v
  - idx increments
- Final lane: at the edge processing idx=NUM_CLASS-1:
  - register class_o=best_idx, max_o=best, margin_o=best-second (computed at DATA_WIDTH+1 bits, always ≥0)
  - valid_o=1 for exactly one cycle; state to IDLE; busy_o=0
- Latency: valid_o is high in the cycle following edge E0+(NUM_CLASS-1), i.e. 6 cycles for 7 classes. The next vector is accepted at edge E0+NUM_CLASS or later.
- Result outputs: class_o, max_o and margin_o hold their values until the next result, so they are valid outside the strobe.
- Ties: the lowest index wins. An equal value updates second, so a tie gives margin_o=0.
- valid_i sampled while in SCAN (including the final-lane edge): ignored, data is not latched, drop_o pulses for one cycle, and the in-progress scan is unaffected.
- data_i is don't-care when valid_i is low.
- No arithmetic overflow is possible: the margin range is 0..2^DATA_WIDTH-1.

Decomposition:
- Package dense_pkg: DATA_WIDTH and NUM_CLASS constants, a signed logit_t typedef, and the state enum {IDLE, SCAN}. dense_top shares the class count.
- One natural sub-module: top2_update. It is combinational: it takes best/second/best_idx and a candidate and returns the next values. This keeps the compare rule unit-testable.
- The FSM, index counter and output registers live in dense_argmax.

Test Plan:
1. Lanes 0..6 = 05,12,7F,40,F0,00,33 with a valid_i pulse at E0 → valid_o one cycle after E0+6; class_o=2, max_o=7F, margin_o=03F; busy_o high in cycles 1..6.
2. All negative, lanes = 80,81,FF,90,FE,A0,C0 → class_o=2, max_o=FF, margin_o=001. Checks signed compare: a wrongly unsigned compare would still pick 2 here, so also run lanes = 7F,FF,... → class 0.
3. Tie, lanes 1 and 5 = 30, others 10 → class_o=1, max_o=30, margin_o=000.
4. Full range, lane0=7F, lanes1..6=80 → class_o=0, max_o=7F, margin_o=0FF.
5. Overlap: vector A at E0, vector B at E0+3 → drop_o pulse after E0+3; result is A's only. Vector C at E0+6 → dropped. Vector C at E0+7 → accepted, valid_o after E0+13.
6. Reset mid-scan: vector at E0, rstn low at E0+3 for 2 cycles → all outputs 0, no valid_o. A new vector after release scans normally with the expected result.
